bp_dram_link_interleaver: RTL and testbench

- Sits between the BlackParrot UCE memory-command port and N manycore DRAM links (one bp_cce_to_mc_mmio bridge per link).
- Steers each memory command to a link chosen by the cache-block-interleave address bits.
- Returns responses to the core in strict command-issue order, using an order FIFO of link IDs.
- Tracks per-link outstanding counts and flags protocol violations with a sticky error output.

---
 rtl/bp_dram_link_interleaver.sv | 158 +++++++++++++++
 tb/tb_bp_dram_link_interleaver.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_dram_link_interleaver.sv
// bp_dram_link_interleaver: steers UCE memory commands to one of several DRAM
// links by cache-block-interleave address bits, and returns the link responses
// to the core in strict command-issue order using an order FIFO of link IDs.
//
// Handshakes: the command port is ready/valid (a command is accepted on a cycle
// with cmd_v_i & cmd_ready_o, and cmd_ready_o never depends on cmd_v_i or on a
// same-cycle pop). Each link command port is the same ready/valid form. Each
// response port is valid/yumi: yumi is only raised when valid is already high,
// and the consumer takes the beat on that cycle.
module bp_dram_link_interleaver #(
   parameter int num_links_p       = 2,
   parameter int msg_width_p       = 128,
   parameter int addr_lsb_p        = 8,
   parameter int paddr_width_p     = 40,
   parameter int block_offset_p    = 6,
   parameter int max_outstanding_p = 8
) (
   input  logic                               clk_i,
   input  logic                               reset_i,
   input  logic [msg_width_p-1:0]             cmd_i,
   input  logic                               cmd_v_i,
   output logic                               cmd_ready_o,
   output logic [msg_width_p-1:0]             resp_o,
   output logic                               resp_v_o,
   input  logic                               resp_yumi_i,
   output logic [num_links_p*msg_width_p-1:0] link_cmd_o,
   output logic [num_links_p-1:0]             link_cmd_v_o,
   input  logic [num_links_p-1:0]             link_cmd_ready_i,
   input  logic [num_links_p*msg_width_p-1:0] link_resp_i,
   input  logic [num_links_p-1:0]             link_resp_v_i,
   output logic [num_links_p-1:0]             link_resp_yumi_o,
   output logic                               error_o
);

   localparam int sel_w_lp = (num_links_p > 1) ? $clog2(num_links_p) : 1;
   localparam int ptr_w_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
   localparam int cnt_w_lp = $clog2(max_outstanding_p) + 1;

   logic [sel_w_lp-1:0]    w_sel;
   logic [sel_w_lp-1:0]    w_head;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_stray;
   logic [num_links_p-1:0] w_inc;
   logic [num_links_p-1:0] w_cnt_zero;
   logic [msg_width_p-1:0] w_link_resp [num_links_p];

   logic [ptr_w_lp-1:0]    r_wptr;
   logic [ptr_w_lp-1:0]    r_rptr;
   logic [cnt_w_lp-1:0]    r_count;
   logic [sel_w_lp-1:0]    r_order [max_outstanding_p];
   logic [cnt_w_lp-1:0]    r_cnt [num_links_p];
   logic                   r_error;

   // Link select comes straight from the block-interleave bits of the paddr field.
   generate
      if (num_links_p > 1) begin : g_sel
         assign w_sel = cmd_i[addr_lsb_p + block_offset_p +: sel_w_lp];
      end else begin : g_sel_one
         assign w_sel = '0;
      end
   endgenerate

   // Pointers wrap at the FIFO depth.
   function automatic logic [ptr_w_lp-1:0] f_ptr_inc(input logic [ptr_w_lp-1:0] p);
      if (p == ptr_w_lp'(max_outstanding_p - 1)) begin
         return '0;
      end
      return p + ptr_w_lp'(1);
   endfunction

   assign w_full  = (r_count == cnt_w_lp'(max_outstanding_p));
   assign w_empty = (r_count == '0);
   assign w_head  = r_order[r_rptr];

   // Full blocks acceptance even if the head is being popped this cycle.
   assign cmd_ready_o = link_cmd_ready_i[w_sel] & ~w_full;
   assign w_push      = cmd_v_i & cmd_ready_o;

   // Only the link at the head of the order FIFO may hand a response back.
   assign resp_v_o = ~w_empty & link_resp_v_i[w_head];
   assign resp_o   = w_link_resp[w_head];
   assign w_pop    = resp_yumi_i & resp_v_o;

   // Per-link fan-out of commands and fan-in of responses.
   generate
      for (genvar j = 0; j < num_links_p; j++) begin : g_link
         assign link_cmd_o[j*msg_width_p +: msg_width_p] = cmd_i;
         assign link_cmd_v_o[j]     = cmd_v_i & (w_sel == sel_w_lp'(j)) & ~w_full;
         assign w_inc[j]            = link_cmd_v_o[j] & cmd_ready_o;
         assign link_resp_yumi_o[j] = w_pop & (w_head == sel_w_lp'(j));
         assign w_link_resp[j]      = link_resp_i[j*msg_width_p +: msg_width_p];
         assign w_cnt_zero[j]       = (r_cnt[j] == '0);
      end
   endgenerate

   // A response from a link with nothing outstanding is a protocol violation.
   assign w_stray = |(link_resp_v_i & w_cnt_zero);

   // Order FIFO storage; contents need no reset because occupancy guards reads.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_order[r_wptr] <= w_sel;
      end
   end

   // Order FIFO pointers and occupancy; push and pop together leave occupancy unchanged.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= f_ptr_inc(r_wptr);
         end
         if (w_pop) begin
            r_rptr <= f_ptr_inc(r_rptr);
         end
         if (w_push & ~w_pop) begin
            r_count <= r_count + cnt_w_lp'(1);
         end else if (w_pop & ~w_push) begin
            r_count <= r_count - cnt_w_lp'(1);
         end
      end
   end

   // Per-link outstanding counters; bounded by FIFO occupancy so they cannot wrap.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int j = 0; j < num_links_p; j++) begin
            r_cnt[j] <= '0;
         end
      end else begin
         for (int j = 0; j < num_links_p; j++) begin
            if (w_inc[j] & ~link_resp_yumi_o[j]) begin
               r_cnt[j] <= r_cnt[j] + cnt_w_lp'(1);
            end else if (link_resp_yumi_o[j] & ~w_inc[j]) begin
               r_cnt[j] <= r_cnt[j] - cnt_w_lp'(1);
            end
         end
      end
   end

   // Sticky error flag: stray responses or a consume with nothing valid.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_error <= 1'b0;
      end else begin
         r_error <= r_error | w_stray | (resp_yumi_i & ~resp_v_o);
      end
   end

   assign error_o = r_error;

endmodule

// File: tb/tb_bp_dram_link_interleaver.sv
// Bench for bp_dram_link_interleaver: directed vectors with literal expectations
// and a queue-based reference model compared against the outputs every cycle.
module tb_bp_dram_link_interleaver;

   localparam int NL    = 2;
   localparam int W     = 128;
   localparam int DEPTH = 8;

   // ---------------- clock / reset ----------------
   logic clk_i   = 1'b0;
   logic reset_i = 1'b1;
   always #5 clk_i = ~clk_i;

   logic [W-1:0]    cmd_i;
   logic            cmd_v_i;
   logic            cmd_ready_o;
   logic [W-1:0]    resp_o;
   logic            resp_v_o;
   logic            resp_yumi_i;
   logic [NL*W-1:0] link_cmd_o;
   logic [NL-1:0]   link_cmd_v_o;
   logic [NL-1:0]   link_cmd_ready_i;
   logic [NL*W-1:0] link_resp_i;
   logic [NL-1:0]   link_resp_v_i;
   logic [NL-1:0]   link_resp_yumi_o;
   logic            error_o;

   logic [W-1:0] lr [NL];
   assign link_resp_i = {lr[1], lr[0]};

   bp_dram_link_interleaver #(
      .num_links_p(NL), .msg_width_p(W), .addr_lsb_p(8), .paddr_width_p(40),
      .block_offset_p(6), .max_outstanding_p(DEPTH)
   ) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .cmd_i(cmd_i), .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o),
      .resp_o(resp_o), .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i),
      .link_cmd_o(link_cmd_o), .link_cmd_v_o(link_cmd_v_o), .link_cmd_ready_i(link_cmd_ready_i),
      .link_resp_i(link_resp_i), .link_resp_v_i(link_resp_v_i), .link_resp_yumi_o(link_resp_yumi_o),
      .error_o(error_o)
   );

   // ---------------- scoreboard counters ----------------
   int n_checks = 0;
   int n_errors = 0;
   bit run_cmp  = 1'b0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] mk_cmd(input logic [39:0] pa, input logic [31:0] tag);
      logic [W-1:0] m;
      m = '0;
      m[8 +: 40]  = pa;
      m[127:96]   = tag;
      return m;
   endfunction

   function automatic logic [W-1:0] resp_msg(input logic [31:0] tag);
      return {64'h0, 32'hF00D_0000, tag};
   endfunction

   // ---------------- reference model ----------------
   // Issue order kept as a queue of link IDs plus a per-link outstanding tally.
   int ord_q[$];
   int m_cnt[NL] = '{default: 0};
   bit m_err     = 1'b0;

   function automatic int m_sel(input logic [W-1:0] c);
      logic [39:0] pa;
      pa = c[8 +: 40];
      return int'(pa[6]);
   endfunction

   function automatic bit m_resp_v();
      return (ord_q.size() > 0) && link_resp_v_i[ord_q[0]];
   endfunction

   bit mu_push, mu_pop, mu_rv;
   int mu_s;
   always @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         ord_q.delete();
         m_cnt = '{default: 0};
         m_err = 1'b0;
      end else begin
         mu_s    = m_sel(cmd_i);
         mu_rv   = m_resp_v();
         mu_push = cmd_v_i && link_cmd_ready_i[mu_s] && (ord_q.size() < DEPTH);
         mu_pop  = resp_yumi_i && mu_rv;
         for (int j = 0; j < NL; j++) begin
            if (link_resp_v_i[j] && (m_cnt[j] == 0)) m_err = 1'b1;
         end
         if (resp_yumi_i && !mu_rv) m_err = 1'b1;
         if (mu_pop) begin
            m_cnt[ord_q[0]]--;
            void'(ord_q.pop_front());
         end
         if (mu_push) begin
            ord_q.push_back(mu_s);
            m_cnt[mu_s]++;
         end
      end
   end

   // Every-cycle comparison, sampled on the falling edge.
   int  cc_s;
   bit  cc_full, cc_rv;
   always @(negedge clk_i) begin
      if (run_cmp) begin
         cc_s    = m_sel(cmd_i);
         cc_full = (ord_q.size() >= DEPTH);
         cc_rv   = m_resp_v();
         check("cmp_cmd_ready", cmd_ready_o, link_cmd_ready_i[cc_s] && !cc_full);
         check("cmp_link_cmd_v", link_cmd_v_o, (cmd_v_i && !cc_full) ? (1 << cc_s) : 0);
         check("cmp_link_cmd", link_cmd_o, {cmd_i, cmd_i});
         check("cmp_resp_v", resp_v_o, cc_rv);
         if (ord_q.size() > 0) check("cmp_resp_data", resp_o, lr[ord_q[0]]);
         check("cmp_link_yumi", link_resp_yumi_o, (resp_yumi_i && cc_rv) ? (1 << ord_q[0]) : 0);
         check("cmp_error", error_o, m_err);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // ---------------- directed sequence ----------------
   int h, nxt;
   initial begin
      cmd_i = '0; cmd_v_i = 1'b0; resp_yumi_i = 1'b0;
      link_cmd_ready_i = 2'b11; link_resp_v_i = 2'b00;
      lr[0] = '0; lr[1] = '0;
      run_cmp = 1'b1;

      // Reset state
      repeat (3) @(posedge clk_i);
      #1;
      check("reset_resp_v", resp_v_o, 0);
      check("reset_error", error_o, 0);
      check("reset_link_cmd_v", link_cmd_v_o, 0);
      check("reset_cmd_ready", cmd_ready_o, 1);
      reset_i = 1'b0;
      step();

      // Two commands interleaved onto link0 then link1
      cmd_i = mk_cmd(40'h8000_0000, 32'hA); cmd_v_i = 1'b1;
      #1 check("t1_first_v", link_cmd_v_o, 2'b01);
      check("t1_first_ready", cmd_ready_o, 1);
      step();
      cmd_i = mk_cmd(40'h8000_0040, 32'hB);
      #1 check("t1_second_v", link_cmd_v_o, 2'b10);
      step();
      cmd_v_i = 1'b0;

      // Link1 answers first and must wait behind link0
      lr[1] = resp_msg(32'hB); link_resp_v_i = 2'b10;
      #1 check("t2_wait_v", resp_v_o, 0);
      check("t2_wait_yumi", link_resp_yumi_o, 2'b00);
      step();
      lr[0] = resp_msg(32'hA); link_resp_v_i = 2'b11; resp_yumi_i = 1'b1;
      #1 check("t2_a_data", resp_o, resp_msg(32'hA));
      check("t2_a_yumi", link_resp_yumi_o, 2'b01);
      step();
      link_resp_v_i = 2'b10;
      #1 check("t2_b_data", resp_o, resp_msg(32'hB));
      check("t2_b_yumi", link_resp_yumi_o, 2'b10);
      step();
      link_resp_v_i = 2'b00; resp_yumi_i = 1'b0;

      // Fill the order FIFO on link0
      for (int k = 0; k < 8; k++) begin
         cmd_i = mk_cmd(40'h8000_0000 + k * 128, k); cmd_v_i = 1'b1;
         #1 check("t3_fill_ready", cmd_ready_o, 1);
         step();
      end
      cmd_i = mk_cmd(40'h8000_0400, 32'h9);
      lr[0] = resp_msg(32'h100); link_resp_v_i = 2'b01; resp_yumi_i = 1'b1;
      #1 check("t3_full_ready", cmd_ready_o, 0);
      check("t3_full_link_cmd_v", link_cmd_v_o, 2'b00);
      check("t3_full_pop_yumi", link_resp_yumi_o, 2'b01);
      step();
      link_resp_v_i = 2'b00; resp_yumi_i = 1'b0;
      #1 check("t3_retry_ready", cmd_ready_o, 1);
      check("t3_retry_link_cmd_v", link_cmd_v_o, 2'b01);
      step();
      cmd_v_i = 1'b0;
      for (int k = 0; k < 8; k++) begin
         lr[0] = resp_msg(32'h101 + k); link_resp_v_i = 2'b01; resp_yumi_i = 1'b1;
         #1 check("t3_drain_data", resp_o, resp_msg(32'h101 + k));
         step();
      end
      link_resp_v_i = 2'b00; resp_yumi_i = 1'b0;

      // Steady stream: one push and one pop per cycle across pointer wrap
      cmd_i = mk_cmd(40'h8000_0000, 32'h0); cmd_v_i = 1'b1;
      step();
      for (int k = 0; k < 20; k++) begin
         nxt = (k + 1) % 2;
         h   = k % 2;
         cmd_i = mk_cmd(40'h8000_0000 + nxt * 64 + (k + 1) * 128, k + 1);
         lr[h] = resp_msg(32'h200 + k);
         link_resp_v_i = (h == 0) ? 2'b01 : 2'b10;
         resp_yumi_i = 1'b1;
         #1 check("t4_stream_data", resp_o, resp_msg(32'h200 + k));
         check("t4_stream_yumi", link_resp_yumi_o, (h == 0) ? 2'b01 : 2'b10);
         check("t4_stream_link_cmd_v", link_cmd_v_o, (nxt == 0) ? 2'b01 : 2'b10);
         check("t4_stream_ready", cmd_ready_o, 1);
         step();
      end
      cmd_v_i = 1'b0;
      lr[0] = resp_msg(32'h214); link_resp_v_i = 2'b01; resp_yumi_i = 1'b1;
      #1 check("t4_tail_data", resp_o, resp_msg(32'h214));
      step();
      link_resp_v_i = 2'b00; resp_yumi_i = 1'b0;
      #1 check("t4_no_error", error_o, 0);

      // Stray response from an idle link
      lr[1] = resp_msg(32'hDEAD); link_resp_v_i = 2'b10;
      #1 check("t5_err_before", error_o, 0);
      step();
      link_resp_v_i = 2'b00;
      #1 check("t5_err_set", error_o, 1);
      repeat (3) step();
      check("t5_err_held", error_o, 1);

      // Asynchronous reset with three outstanding
      cmd_v_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cmd_i = mk_cmd(40'h8000_0000 + (k % 2) * 64 + k * 128, k);
         step();
      end
      cmd_v_i = 1'b0;
      lr[0] = resp_msg(32'h300); link_resp_v_i = 2'b01;
      #1 check("t6_pre_resp_v", resp_v_o, 1);
      #1 reset_i = 1'b1;
      #1 check("t6_rst_resp_v", resp_v_o, 0);
      check("t6_rst_error", error_o, 0);
      step();
      step();
      #1 reset_i = 1'b0;
      step();
      check("t6_inflight_error", error_o, 1);
      link_resp_v_i = 2'b00;
      #1 reset_i = 1'b1;
      step();
      #1 reset_i = 1'b0;
      check("t6_cleared_error", error_o, 0);
      cmd_i = mk_cmd(40'h8000_0040, 32'hC); cmd_v_i = 1'b1;
      #1 check("t6_fresh_link_cmd_v", link_cmd_v_o, 2'b10);
      step();
      cmd_v_i = 1'b0;
      lr[1] = resp_msg(32'hC); link_resp_v_i = 2'b10; resp_yumi_i = 1'b1;
      #1 check("t6_fresh_data", resp_o, resp_msg(32'hC));
      check("t6_fresh_yumi", link_resp_yumi_o, 2'b10);
      step();
      link_resp_v_i = 2'b00; resp_yumi_i = 1'b0;

      // Consume with nothing valid
      resp_yumi_i = 1'b1;
      #1 check("t7_err_before", error_o, 0);
      step();
      resp_yumi_i = 1'b0;
      #1 check("t7_err_set", error_o, 1);
      step();

      run_cmp = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
